lab4_net_router_output_credit_ctrl: RTL and testbench

// - Output-port side of the router req/grant protocol: one instance per output (west, terminal, east).
// - Collects per-input requests for this output and issues a one-hot grant, round-robin fair.
// - Tracks credits (free entries) of the downstream input queue; grants only when a credit exists.
// - Exports num_free and a saturated free count for bubble checks and adaptive route compute upstream.
//

---
 rtl/lab4_net_router_output_credit_ctrl_if.sv | 43 ++++
 rtl/lab4_net_router_output_credit_ctrl.sv | 118 +++++++++++
 tb/tb_lab4_net_router_output_credit_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/lab4_net_router_output_credit_ctrl_if.sv
// lab4_net_router_output_credit_ctrl_if
// Request/grant/credit bundle between one router output port and its
// neighbours: per-input requests come in, a one-hot grant goes back, the
// downstream queue returns credits, and free-entry counts are exported.
// Optional: LAB4_NET_OUTPUT_CTRL_STATS_EN adds the 32-bit grant_count signal.
interface lab4_net_router_output_credit_ctrl_if #(
    parameter int p_num_free_nbits = 3,
    parameter int f                = 2
);
    logic [2:0]                  reqs;
    logic [2:0]                  grants;
    logic                        out_val;
    logic                        credit_ret;
    logic [p_num_free_nbits-1:0] num_free;
    logic [f-1:0]                free_sat;
`ifdef LAB4_NET_OUTPUT_CTRL_STATS_EN
    logic [31:0]                 grant_count;

    // Controller side: arbitrates and tracks credits.
    modport master (
        input  reqs, credit_ret,
        output grants, out_val, num_free, free_sat, grant_count
    );

    // Environment side: input controllers, downstream queue, route compute.
    modport slave (
        output reqs, credit_ret,
        input  grants, out_val, num_free, free_sat, grant_count
    );
`else
    // Controller side: arbitrates and tracks credits.
    modport master (
        input  reqs, credit_ret,
        output grants, out_val, num_free, free_sat
    );

    // Environment side: input controllers, downstream queue, route compute.
    modport slave (
        output reqs, credit_ret,
        input  grants, out_val, num_free, free_sat
    );
`endif
endinterface

// File: rtl/lab4_net_router_output_credit_ctrl.sv
// lab4_net_router_output_credit_ctrl
// Output-port controller of the router: round-robin arbitration among the
// west/terminal/east input controllers, gated by credits of the downstream
// input queue. Grants are combinational from the registered credit count and
// priority pointer; a granted input dequeues its flit in the same cycle.
// Optional: define LAB4_NET_OUTPUT_CTRL_STATS_EN to add a wrapping 32-bit
// count of cycles in which a flit left on the channel (grant_count).
module lab4_net_router_output_credit_ctrl #(
    parameter int p_num_entries    = 4,
    parameter int p_num_free_nbits = 3,
    parameter int f                = 2
) (
    input  logic clk,
    input  logic reset,
    lab4_net_router_output_credit_ctrl_if.master bus
);

    localparam logic [p_num_free_nbits-1:0] lp_max_credits = p_num_free_nbits'(p_num_entries);
    localparam logic [p_num_free_nbits-1:0] lp_one         = p_num_free_nbits'(1);
    localparam logic [p_num_free_nbits-1:0] lp_zero        = '0;
    localparam int                          lp_sat_max     = (2 ** f) - 1;

    logic [p_num_free_nbits-1:0] r_credits;
    logic [2:0]                  r_prio;      // one-hot: input with highest priority
    logic [2:0]                  w_grants;
    logic                        w_out_val;
    logic [p_num_free_nbits-1:0] w_credits_next;
    logic [f-1:0]                w_free_sat;

    // Round-robin pick starting at the priority input, only when a credit is held.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no input combination can leave it holding a value (a latch).
        w_grants = 3'b000;
        if (!reset && (r_credits != lp_zero)) begin
            case (r_prio)
                3'b001: begin
                    if      (bus.reqs[0]) w_grants = 3'b001;
                    else if (bus.reqs[1]) w_grants = 3'b010;
                    else if (bus.reqs[2]) w_grants = 3'b100;
                end
                3'b010: begin
                    if      (bus.reqs[1]) w_grants = 3'b010;
                    else if (bus.reqs[2]) w_grants = 3'b100;
                    else if (bus.reqs[0]) w_grants = 3'b001;
                end
                3'b100: begin
                    if      (bus.reqs[2]) w_grants = 3'b100;
                    else if (bus.reqs[0]) w_grants = 3'b001;
                    else if (bus.reqs[1]) w_grants = 3'b010;
                end
                default: w_grants = 3'b000;
            endcase
        end
    end

    assign w_out_val = |w_grants;

    // Credit bookkeeping: a send consumes one, a return restores one; both cancel.
    always_comb begin
        w_credits_next = r_credits;
        if (w_out_val && !bus.credit_ret) begin
            w_credits_next = r_credits - lp_one;
        end else if (!w_out_val && bus.credit_ret && (r_credits != lp_max_credits)) begin
            // A return while already full is a protocol error; the count saturates.
            w_credits_next = r_credits + lp_one;
        end
    end

    // Credit counter and priority pointer; winner of a grant becomes lowest priority.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_credits <= lp_max_credits;
            r_prio    <= 3'b001;
        end else begin
            r_credits <= w_credits_next;
            if (w_out_val) begin
                r_prio <= {w_grants[1:0], w_grants[2]};
            end
        end
    end

    // Saturated free count for adaptive route compute upstream.
    always_comb begin
        if (int'(r_credits) > lp_sat_max) begin
            w_free_sat = f'(lp_sat_max);
        end else begin
            w_free_sat = f'(r_credits);
        end
    end

    assign bus.grants   = w_grants;
    assign bus.out_val  = w_out_val;
    assign bus.num_free = r_credits;
    assign bus.free_sat = w_free_sat;

`ifdef LAB4_NET_OUTPUT_CTRL_STATS_EN
    logic [31:0] r_grant_count;

    // Count cycles with a flit on the channel; wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_count <= 32'd0;
        end else if (w_out_val) begin
            r_grant_count <= r_grant_count + 32'd1;
        end
    end

    assign bus.grant_count = r_grant_count;
`endif

    // Downstream must never return a credit the controller does not owe it.
    a_credit_overflow : assert property (
        @(posedge clk) disable iff (reset)
        !(bus.credit_ret && !w_out_val && (r_credits == lp_max_credits))
    ) else $error("credit_ret received while all credits are free");

endmodule

// File: tb/tb_lab4_net_router_output_credit_ctrl.sv
// tb_lab4_net_router_output_credit_ctrl
// Directed scenarios with literal expectations followed by randomized
// traffic, all compared every cycle against a queue-level reference model
// (free-entry count, index of the highest-priority input, send counter).
module tb_lab4_net_router_output_credit_ctrl;

    localparam int lp_entries = 4;
    localparam int lp_sat     = 3;

    logic clk = 1'b0;
    logic reset;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state, valid once a reset edge has been seen.
    int          m_credits = 0;
    int          m_prio    = 0;
    bit          m_valid   = 1'b0;
    logic [31:0] m_count   = 32'd0;

    lab4_net_router_output_credit_ctrl_if #(.p_num_free_nbits(3), .f(2)) bus ();

    lab4_net_router_output_credit_ctrl #(
        .p_num_entries   (lp_entries),
        .p_num_free_nbits(3),
        .f               (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner = first requesting input scanning upward from the priority index.
    function automatic logic [2:0] model_grant(input logic rst, input int cred,
                                               input int pr, input logic [2:0] rq);
        if (rst || cred == 0) return 3'b000;
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (pr + k) % 3;
            if (rq[i]) return 3'(1 << i);
        end
        return 3'b000;
    endfunction

    function automatic int win_index(input logic [2:0] g);
        for (int i = 0; i < 3; i++) if (g[i]) return i;
        return 0;
    endfunction

    // Apply one cycle of stimulus just after the edge; return at the next falling edge.
    task automatic cycle(input logic rst, input logic [2:0] r, input logic c);
        @(posedge clk);
        #1;
        reset          = rst;
        bus.reqs       = r;
        bus.credit_ret = c;
        @(negedge clk);
    endtask

    // Compare DUT against the model on every falling edge, then advance the model.
    initial begin : compare
        logic [2:0] exp_g;
        forever begin
            @(negedge clk);
            exp_g = model_grant(reset, m_credits, m_prio, bus.reqs);
            check("grants", 32'(bus.grants), 32'(exp_g));
            check("out_val", 32'(bus.out_val), 32'(|exp_g));
            if (m_valid) begin
                check("num_free", 32'(bus.num_free), 32'(m_credits));
                check("free_sat", 32'(bus.free_sat), 32'((m_credits > lp_sat) ? lp_sat : m_credits));
`ifdef LAB4_NET_OUTPUT_CTRL_STATS_EN
                check("grant_count", bus.grant_count, m_count);
`endif
            end
            if (reset) begin
                m_credits = lp_entries;
                m_prio    = 0;
                m_count   = 32'd0;
                m_valid   = 1'b1;
            end else if (m_valid) begin
                if (exp_g != 3'b000) begin
                    m_credits = m_credits - 1;
                    m_prio    = (win_index(exp_g) + 1) % 3;
                    m_count   = m_count + 32'd1;
                end
                if (bus.credit_ret) m_credits = m_credits + 1;
                if (m_credits > lp_entries) m_credits = lp_entries;
            end
        end
    end

    // Hard stop if the run never reaches its summary.
    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [2:0] rr_seq [3];
        logic [2:0] r;
        logic       rs;
        logic       c;

        rr_seq = '{3'b001, 3'b010, 3'b100};

        reset          = 1'b1;
        bus.reqs       = 3'bxxx;
        bus.credit_ret = 1'b0;

        // Reset with undefined requests, then idle.
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'bxxx, 1'b0);
        check("rst_grants", 32'(bus.grants), 32'd0);
        cycle(1'b0, 3'b000, 1'b0);
        check("idle_grants", 32'(bus.grants), 32'd0);
        check("idle_num_free", 32'(bus.num_free), 32'd4);
        check("idle_free_sat", 32'(bus.free_sat), 32'd3);
`ifdef LAB4_NET_OUTPUT_CTRL_STATS_EN
        check("idle_grant_count", bus.grant_count, 32'd0);
`endif

        // All request, credit returned every cycle: rotation with full credits.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 3'b111, 1'b1);
            check("rot_grants", 32'(bus.grants), 32'(rr_seq[i % 3]));
            check("rot_num_free", 32'(bus.num_free), 32'd4);
        end

        // All request, no returns: four sends drain the credits.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 3'b111, 1'b0);
            check("drain_grants", 32'(bus.grants), 32'(rr_seq[i % 3]));
            check("drain_num_free", 32'(bus.num_free), 32'(4 - i));
        end
        cycle(1'b0, 3'b111, 1'b0);
        check("empty_grants", 32'(bus.grants), 32'd0);
        check("empty_num_free", 32'(bus.num_free), 32'd0);
        check("empty_free_sat", 32'(bus.free_sat), 32'd0);

        // Credit return at zero: no same-cycle grant, one grant next cycle.
        cycle(1'b0, 3'b111, 1'b1);
        check("ret0_grants", 32'(bus.grants), 32'd0);
        cycle(1'b0, 3'b111, 1'b0);
        check("ret1_num_free", 32'(bus.num_free), 32'd1);
        check("ret1_grants", 32'(bus.grants), 32'b010);
        cycle(1'b0, 3'b111, 1'b0);
        check("ret2_num_free", 32'(bus.num_free), 32'd0);
        check("ret2_grants", 32'(bus.grants), 32'd0);

        // Grant and return in the same cycle with two credits.
        cycle(1'b0, 3'b000, 1'b1);
        cycle(1'b0, 3'b000, 1'b1);
        cycle(1'b0, 3'b100, 1'b1);
        check("simul_grants", 32'(bus.grants), 32'b100);
        check("simul_num_free", 32'(bus.num_free), 32'd2);
        cycle(1'b0, 3'b000, 1'b0);
        check("simul_after_num_free", 32'(bus.num_free), 32'd2);
        cycle(1'b0, 3'b111, 1'b0);
        check("simul_prio_wrap", 32'(bus.grants), 32'b001);

        // Reset mid-burst with credits=1, prio at terminal.
        cycle(1'b1, 3'b111, 1'b0);
        check("midrst_grants", 32'(bus.grants), 32'd0);
        check("midrst_num_free", 32'(bus.num_free), 32'd1);
        cycle(1'b0, 3'b000, 1'b0);
        check("postrst_num_free", 32'(bus.num_free), 32'd4);
`ifdef LAB4_NET_OUTPUT_CTRL_STATS_EN
        check("postrst_grant_count", bus.grant_count, 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 3'b111, 1'b0);
            check("postrst_grants", 32'(bus.grants), 32'(rr_seq[i]));
        end
        cycle(1'b0, 3'b000, 1'b0);
        check("postrst_left", 32'(bus.num_free), 32'd1);
`ifdef LAB4_NET_OUTPUT_CTRL_STATS_EN
        check("postrst_count3", bus.grant_count, 32'd3);
`endif

        // Randomized traffic; returns only when the downstream queue has an entry to free.
        for (int n = 0; n < 4000; n++) begin
            r  = 3'($urandom_range(0, 7));
            rs = ($urandom_range(0, 99) == 0);
            if (n < 2000) c = ($urandom_range(0, 3) != 0);
            else          c = ($urandom_range(0, 3) == 0);
            if (c && m_credits >= lp_entries &&
                model_grant(1'b0, m_credits, m_prio, r) == 3'b000) begin
                c = 1'b0;
            end
            cycle(rs, r, c);
        end

        cycle(1'b0, 3'b000, 1'b0);
        cycle(1'b0, 3'b000, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
